mtr_drv: RTL and testbench
==========================

Name: mtr_drv

Overview:
- Motor driver block: converts signed 11-bit left/right wheel speed commands into complementary PWM pairs for two H-bridges.
- Each side has its own duty register, driven by one shared 11-bit free-running period counter.
- Zero speed gives 50% duty on both PWM1 and PWM2, i.e. zero average motor voltage.
- Sits between the PID/steering logic and the motor-driver pins.

Parameters:
- DEADTIME, 0, non-overlap cycles inserted after every PWM1/PWM2 transition, during which both outputs of that side are low. Legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- lft_spd  input  11  signed left speed, range -1024..+1023
- rght_spd  input  11  signed right speed, range -1024..+1023
- lftPWM1  output  1  left H-bridge forward-side PWM
- lftPWM2  output  1  left H-bridge reverse-side PWM (complement of lftPWM1)
- rghtPWM1  output  1  right H-bridge forward-side PWM
- rghtPWM2  output  1  right H-bridge reverse-side PWM

Behaviour:
- Reset is synchronous and active-low: sampled on the rising clk edge while rst_n=0.
  - cnt=0
  - both duty registers = 11'h400
  - all four PWM outputs = 0
  - dead-time counters = 0
- Period counter cnt (11 bits):
  - increments every clock after reset.
  - wraps 2047->0, so the PWM period is 2048 clocks.
- Duty mapping: duty = spd + 0x400 (mod 2048), i.e. invert spd[10].
  - -1024 -> 0
  - 0 -> 1024
  - +1023 -> 2047
- Duty update timing:
  - Duty registers load the mapped speed when cnt==2047, so a new value takes effect at the start of the next period.
  - A speed change mid-period never produces a glitch within the current period.
- Raw compare per side: raw = (cnt < duty_q), unsigned compare.
- DEADTIME=0:
  - PWM1 <= raw and PWM2 <= ~raw, registered, one-cycle latency after cnt.
  - PWM1 high exactly duty_q clocks per period.
- DEADTIME=N>0:
  - When raw changes, both outputs of that side go low.
  - The newly active output asserts only after raw has been stable for N consecutive clocks.
  - Each output's high time shrinks by N clocks per edge; it never goes negative (an output whose active window is <=N stays low).
- Boundary behaviour:
  - duty 0: PWM1 constantly 0, PWM2 constantly 1 (DEADTIME=0).
  - duty 2047: PWM1 high 2047 of 2048 clocks, PWM2 high 1 clock per period.
  - Duty 2048 is not reachable.
- PWM1 and PWM2 of the same side are never simultaneously 1 under any DEADTIME value or input change.
- Left and right channels are fully independent apart from the shared cnt.
- Reset asserted mid-period: on the next edge, outputs go low, cnt=0 and duty registers = 0x400.
- After reset deassertion, the first PWM period uses duty 0x400 (50%) until the first cnt==2047 load.

Test Plan:
- rst_n=0 for 1 clk, speeds=0 -> all PWM outputs 0 during reset. After release, lftPWM1/rghtPWM1 high 1024 of every 2048 clocks; PWM2 is the complement.
- lft_spd=11'h3ff, rght_spd=11'h400, measured over a full period after the next cnt wrap:
  - lftPWM1 high 2047/2048 clocks, lftPWM2 high 1/2048.
  - rghtPWM1 constantly 0, rghtPWM2 constantly 1.
- lft_spd=11'h400, rght_spd=11'h3ff -> mirror of the previous case: lftPWM1 0%, lftPWM2 100%, rghtPWM1 2047/2048.
- Change lft_spd from 0 to 11'h200 at cnt=500 -> current period stays at 1024 high clocks; next period lftPWM1 high exactly 1536 clocks.
- DEADTIME=4, speed 0 -> each output high 1020 clocks per period; both outputs of a side low for 4 clocks after each edge; PWM1&PWM2 never both 1.
- Assert rst_n=0 at cnt=700 for 1 clk -> outputs 0 on next edge; after release, cnt restarts at 0 with 50% duty.

Source files
------------

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: signed left/right speeds become complementary PWM pairs with
// optional non-overlap dead time. A single free-running 11-bit counter sets the 2048-clock period.
module mtr_drv #(
  parameter int unsigned DEADTIME = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2
);

  logic [10:0] r_cnt;
  logic [10:0] r_lft_duty;
  logic [10:0] r_rght_duty;
  logic [1:0]  w_raw;     // index 0 = left, 1 = right
  logic [1:0]  r_pwm1;
  logic [1:0]  r_pwm2;

  // Period counter; the duty registers reload only at the end of a period so mid-period
  // speed changes cannot glitch the current cycle. Adding 0x400 flips the sign bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 11'd0;
      r_lft_duty  <= 11'h400;
      r_rght_duty <= 11'h400;
    end else begin
      r_cnt <= r_cnt + 11'd1;
      if (r_cnt == 11'h7ff) begin
        r_lft_duty  <= {~lft_spd[10], lft_spd[9:0]};
        r_rght_duty <= {~rght_spd[10], rght_spd[9:0]};
      end
    end
  end

  assign w_raw[0] = (r_cnt < r_lft_duty);
  assign w_raw[1] = (r_cnt < r_rght_duty);

  generate
    if (DEADTIME == 0) begin : g_nodt
      // Plain registered compare: PWM1 follows raw, PWM2 is its complement.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_pwm1 <= 2'b00;
          r_pwm2 <= 2'b00;
        end else begin
          r_pwm1 <= w_raw;
          r_pwm2 <= ~w_raw;
        end
      end
    end else begin : g_dt
      localparam logic [3:0] DtCyc = 4'(DEADTIME);

      logic [1:0] r_raw_q;
      logic [3:0] r_dt [2];

      // Per side: any raw edge forces both outputs low; r_dt counts consecutive stable
      // samples (the edge sample counts as the first) and the new output is released once
      // raw has held for DEADTIME clocks.
      always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
          if (!rst_n) begin
            r_raw_q[s] <= 1'b0;
            r_dt[s]    <= 4'd0;
            r_pwm1[s]  <= 1'b0;
            r_pwm2[s]  <= 1'b0;
          end else begin
            r_raw_q[s] <= w_raw[s];
            if (w_raw[s] != r_raw_q[s]) begin
              r_dt[s]   <= 4'd1;
              r_pwm1[s] <= 1'b0;
              r_pwm2[s] <= 1'b0;
            end else if (r_dt[s] >= DtCyc) begin
              r_pwm1[s] <= w_raw[s];
              r_pwm2[s] <= ~w_raw[s];
            end else begin
              r_dt[s]   <= r_dt[s] + 4'd1;
              r_pwm1[s] <= 1'b0;
              r_pwm2[s] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  assign lftPWM1  = r_pwm1[0];
  assign lftPWM2  = r_pwm2[0];
  assign rghtPWM1 = r_pwm1[1];
  assign rghtPWM2 = r_pwm2[1];

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: one instance without dead time, one with DEADTIME=4.
// Counts high clocks over aligned 2048-clock windows and compares with hand-computed values.
module tb_mtr_drv;

  logic        clk;
  logic        rst_n;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic [10:0] zero_spd;
  logic        l1_a, l2_a, r1_a, r2_a;
  logic        l1_b, l2_b, r1_b, r2_b;

  int n_chk;
  int n_fail;

  // per-window counters
  int a_l1, a_l2, a_r1, a_r2, a_leq, a_req;
  int b_l1, b_l2, b_r1, b_r2, b_llow, b_rlow, b_lov, b_rov;

  mtr_drv #(.DEADTIME(0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_spd (lft_spd),
    .rght_spd(rght_spd),
    .lftPWM1 (l1_a),
    .lftPWM2 (l2_a),
    .rghtPWM1(r1_a),
    .rghtPWM2(r2_a)
  );

  mtr_drv #(.DEADTIME(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_spd (zero_spd),
    .rght_spd(zero_spd),
    .lftPWM1 (l1_b),
    .lftPWM2 (l2_b),
    .rghtPWM1(r1_b),
    .rghtPWM2(r2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sample one full output period (first sample follows the edge that saw cnt=0).
  // At sample chg_idx the speeds switch to nl/nr; they take effect next window.
  task automatic run_period(input int chg_idx, input logic [10:0] nl, input logic [10:0] nr);
    a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; a_leq = 0; a_req = 0;
    b_l1 = 0; b_l2 = 0; b_r1 = 0; b_r2 = 0; b_llow = 0; b_rlow = 0; b_lov = 0; b_rov = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      a_l1  += int'(l1_a);
      a_l2  += int'(l2_a);
      a_r1  += int'(r1_a);
      a_r2  += int'(r2_a);
      a_leq += int'(l1_a == l2_a);
      a_req += int'(r1_a == r2_a);
      b_l1  += int'(l1_b);
      b_l2  += int'(l2_b);
      b_r1  += int'(r1_b);
      b_r2  += int'(r2_b);
      b_llow += int'(!l1_b && !l2_b);
      b_rlow += int'(!r1_b && !r2_b);
      b_lov  += int'(l1_b && l2_b);
      b_rov  += int'(r1_b && r2_b);
      if (i == chg_idx) begin
        lft_spd  = nl;
        rght_spd = nr;
      end
    end
  endtask

  task automatic check_a(input string tag, input int el1, input int el2, input int er1,
                         input int er2);
    check({tag, " lftPWM1 high"},  a_l1, el1);
    check({tag, " lftPWM2 high"},  a_l2, el2);
    check({tag, " rghtPWM1 high"}, a_r1, er1);
    check({tag, " rghtPWM2 high"}, a_r2, er2);
    check({tag, " lft not complementary"},  a_leq, 0);
    check({tag, " rght not complementary"}, a_req, 0);
  endtask

  // Speed 0 with DEADTIME=4: 1024-4 high per output, 4 dead clocks after each of 2 edges.
  task automatic check_b(input string tag);
    check({tag, " dt lftPWM1 high"},  b_l1, 1020);
    check({tag, " dt lftPWM2 high"},  b_l2, 1020);
    check({tag, " dt rghtPWM1 high"}, b_r1, 1020);
    check({tag, " dt rghtPWM2 high"}, b_r2, 1020);
    check({tag, " dt lft both low"},  b_llow, 8);
    check({tag, " dt rght both low"}, b_rlow, 8);
    check({tag, " dt lft overlap"},   b_lov, 0);
    check({tag, " dt rght overlap"},  b_rov, 0);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    lft_spd  = 11'h000;
    rght_spd = 11'h000;
    zero_spd = 11'h000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs dt0", int'({l1_a, l2_a, r1_a, r2_a}), 0);
    check("reset outputs dt4", int'({l1_b, l2_b, r1_b, r2_b}), 0);
    rst_n = 1'b1;

    // P0: 50%; lft changes to 0x200 at cnt=500 but this window must stay 1024.
    run_period(500, 11'h200, 11'h000);
    check_a("p0", 1024, 1024, 1024, 1024);
    check_b("p0");

    // P1: lft duty 0x600 = 1536; then request full forward / full reverse.
    run_period(10, 11'h3ff, 11'h400);
    check_a("p1", 1536, 512, 1024, 1024);
    check_b("p1");

    // P2: lft duty 2047, rght duty 0; then mirror.
    run_period(10, 11'h400, 11'h3ff);
    check_a("p2", 2047, 1, 0, 2048);
    check_b("p2");

    // P3: mirror case; then queue 2047/0 so the reset must override it.
    run_period(10, 11'h3ff, 11'h400);
    check_a("p3", 0, 2048, 2047, 1);
    check_b("p3");

    // Mid-period reset at cnt=700 (P4 would otherwise use 2047/0).
    for (int i = 0; i <= 700; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outputs dt0", int'({l1_a, l2_a, r1_a, r2_a}), 0);
    check("midreset outputs dt4", int'({l1_b, l2_b, r1_b, r2_b}), 0);
    rst_n = 1'b1;

    // First window after reset: duty back to 0x400 despite pending speeds.
    run_period(-1, 11'h3ff, 11'h400);
    check_a("post-reset", 1024, 1024, 1024, 1024);
    check_b("post-reset");

    // Next window picks up the speeds loaded at the first wrap.
    run_period(-1, 11'h3ff, 11'h400);
    check_a("post-reset load", 2047, 1, 0, 2048);
    check_b("post-reset load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
